// File: rtl/seq_nibble_addsub_if.sv
// seq_nibble_addsub_if
// Request/result bundle for the sequential nibble adder/subtractor.
//   master : drives start, sub, a, b; observes ready, done and the results.
//   slave  : the arithmetic unit itself.
// Signals:
//   start  request, taken only while ready is high
//   sub    0 = a+b, 1 = a-b (sampled with start)
//   a, b   operands (sampled with start)
//   ready  unit idle and able to accept a request
//   done   one-cycle pulse, results valid in that cycle
//   s      result mod 2^WIDTH
//   cout   carry out of the MSB (for subtraction: 1 = no borrow)
//   ovf    two's-complement signed overflow
//   p, g   whole-word group propagate / generate
interface seq_nibble_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             p;
    logic             g;

    modport master (
        output start, sub, a, b,
        input  ready, done, s, cout, ovf, p, g
    );

    modport slave (
        input  start, sub, a, b,
        output ready, done, s, cout, ovf, p, g
    );
endinterface

// File: rtl/seq_nibble_addsub.sv
// seq_nibble_addsub
// Multi-cycle WIDTH-bit adder/subtractor. One 4-bit nibble is summed per
// clock using a nibble-level carry-lookahead; alongside the sum the unit
// accumulates whole-word group propagate/generate, the carry out and the
// signed overflow flag.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    seq_nibble_addsub_if slave modport (start/sub/a/b in,
//          ready/done/s/cout/ovf/p/g out)
module seq_nibble_addsub #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_nibble_addsub_if.slave   bus
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Result of one nibble of lookahead addition.
    typedef struct packed {
        logic [3:0] sum;
        logic       pk;     // nibble propagate
        logic       gk;     // nibble generate
        logic       c_msb;  // carry into bit 3 of the nibble
        logic       c_out;  // carry out of bit 3 of the nibble
    } nib_res_t;

    // 4-bit carry-lookahead: all internal carries come straight from
    // p/g and the carry-in, never rippled.
    function automatic nib_res_t nibble_cla(
        input logic [3:0] a_nib,
        input logic [3:0] b_nib,
        input logic       cin
    );
        logic [3:0] p_b;
        logic [3:0] g_b;
        logic [4:0] c_b;
        nib_res_t   r;
        p_b    = a_nib ^ b_nib;
        g_b    = a_nib & b_nib;
        c_b[0] = cin;
        c_b[1] = g_b[0] | (p_b[0] & cin);
        c_b[2] = g_b[1] | (p_b[1] & g_b[0]) | (p_b[1] & p_b[0] & cin);
        c_b[3] = g_b[2] | (p_b[2] & g_b[1]) | (p_b[2] & p_b[1] & g_b[0])
               | (p_b[2] & p_b[1] & p_b[0] & cin);
        r.pk   = &p_b;
        r.gk   = g_b[3] | (p_b[3] & g_b[2]) | (p_b[3] & p_b[2] & g_b[1])
               | (p_b[3] & p_b[2] & p_b[1] & g_b[0]);
        c_b[4] = r.gk | (r.pk & cin);
        r.sum   = p_b ^ c_b[3:0];
        r.c_msb = c_b[3];
        r.c_out = c_b[4];
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // already inverted for subtraction
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             p_q, p_d;
    logic             g_q, g_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic [$clog2(WIDTH)+1:0] nib_sh_s;
    logic [3:0]               a_nib_s;
    logic [3:0]               b_nib_s;
    nib_res_t                 nib_s;

    // Select the nibble under processing and run it through the lookahead.
    always_comb begin
        nib_sh_s = '0;
        nib_sh_s = ($clog2(WIDTH)+2)'({idx_q, 2'b00});
        a_nib_s  = 4'(a_q >> nib_sh_s);
        b_nib_s  = 4'(b_q >> nib_sh_s);
        nib_s    = nibble_cla(a_nib_s, b_nib_s, carry_q);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        p_d     = p_q;
        g_d     = g_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    p_d     = 1'b0;
                    g_d     = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                s_d     = (s_q & ~(NIB_MASK << nib_sh_s))
                        | (WIDTH'(nib_s.sum) << nib_sh_s);
                carry_d = nib_s.c_out;
                // P was cleared at acceptance, so the first nibble seeds it
                // rather than being ANDed into the cleared value.
                p_d     = (idx_q == '0) ? nib_s.pk : (p_q & nib_s.pk);
                // G chains only gk/pk, so it ignores the latched carry-in.
                g_d     = nib_s.gk | (nib_s.pk & g_q);
                if (idx_q == IDX_LAST) begin
                    cout_d  = nib_s.c_out;
                    ovf_d   = nib_s.c_msb ^ nib_s.c_out;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered from the next state so they
        // line up with the state they describe.
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State, datapath and registered outputs; reset discards any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            p_q     <= 1'b0;
            g_q     <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            p_q     <= p_d;
            g_q     <= g_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.s     = s_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign bus.p     = p_q;
    assign bus.g     = g_q;
endmodule

// File: tb/tb_seq_nibble_addsub.sv
module tb_seq_nibble_addsub;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_nibble_addsub_if #(.WIDTH(W)) ifc ();
    seq_nibble_addsub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        p;
        logic        g;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        res_t        exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: plain word arithmetic on the effective operands.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        res_t r;
        logic [15:0] bq;
        logic [16:0] full;
        logic [16:0] nocin;
        bq    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, bq} + {16'd0, sub};
        nocin = {1'b0, a} + {1'b0, bq};
        r.s    = full[15:0];
        r.cout = full[16];
        r.ovf  = (a[15] == bq[15]) && (full[15] != a[15]);
        r.p    = &(a ^ bq);
        r.g    = nocin[16];
        return r;
    endfunction

    task automatic check_res(input string nm, input res_t e);
        check({nm, ".s"},    {16'd0, ifc.s},    {16'd0, e.s});
        check({nm, ".cout"}, {31'd0, ifc.cout}, {31'd0, e.cout});
        check({nm, ".ovf"},  {31'd0, ifc.ovf},  {31'd0, e.ovf});
        check({nm, ".p"},    {31'd0, ifc.p},    {31'd0, e.p});
        check({nm, ".g"},    {31'd0, ifc.g},    {31'd0, e.g});
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (ifc.ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (ifc.ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one operation and return in the negedge of the done cycle.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub, input string nm);
        int lat;
        int rdy_err;
        wait_ready();
        ifc.a = a; ifc.b = b; ifc.sub = sub; ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.a = 16'($urandom); ifc.b = 16'($urandom); ifc.sub = 1'($urandom);
        lat = 0;
        rdy_err = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) begin
                lat = c;
                break;
            end
            if (ifc.ready !== 1'b0) rdy_err++;
        end
        check({nm, ".latency"}, lat, 32'd5);
        check({nm, ".ready_low"}, rdy_err, 32'd0);
    endtask

    vec_t vecs[6];
    res_t e;
    res_t first_exp;
    int   dcount;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'h0005, 16'h0006, 1'b1, '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[4] = '{16'h0003, 16'h0003, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1}};

        // Reset with start held high: reset must win.
        ifc.start = 1'b1; ifc.sub = 1'b0; ifc.a = 16'h1111; ifc.b = 16'h2222;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.ready", {31'd0, ifc.ready}, 32'd1);
        check("reset.done",  {31'd0, ifc.done},  32'd0);
        check_res("reset", '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        ifc.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, $sformatf("vec%0d", i));
            check_res($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset in RUN cycle 2 discards the operation.
        wait_ready();
        ifc.a = 16'h1234; ifc.b = 16'h4321; ifc.sub = 1'b0; ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.ready", {31'd0, ifc.ready}, 32'd1);
        check("midrst.done",  {31'd0, ifc.done},  32'd0);
        check_res("midrst", '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) dcount++;
        end
        check("midrst.no_done", dcount, 32'd0);

        // Start pulse during RUN is ignored.
        wait_ready();
        ifc.a = 16'h1234; ifc.b = 16'h4321; ifc.sub = 1'b0; ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ifc.a = 16'hFFFF; ifc.b = 16'h0001; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("runstart.done", {31'd0, ifc.done}, 32'd1);
        check_res("runstart", '{16'h5555, 1'b0, 1'b0, 1'b0, 1'b0});
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) dcount++;
        end
        check("runstart.no_second", dcount, 32'd0);

        // Start held from DONE is taken on the first IDLE edge; result holds.
        do_op(16'h7FFF, 16'h0001, 1'b0, "held1");
        first_exp = '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
        ifc.a = 16'h0003; ifc.b = 16'h0003; ifc.sub = 1'b1; ifc.start = 1'b1;
        @(negedge clk);
        check("held.ready_idle", {31'd0, ifc.ready}, 32'd1);
        check_res("held.hold", first_exp);
        @(negedge clk);
        check("held.accepted", {31'd0, ifc.ready}, 32'd0);
        ifc.start = 1'b0;
        dcount = 0;
        for (int c = 2; c <= 12; c++) begin
            if (ifc.done === 1'b1) begin
                dcount = c - 1;
                break;
            end
            @(negedge clk);
        end
        check("held.latency", dcount, 32'd5);
        check_res("held2", '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});

        // Randomised operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            ra = 16'($urandom);
            rb = (i % 5 == 0) ? ~ra : 16'($urandom);
            rs = 1'($urandom);
            e  = model(ra, rb, rs);
            do_op(ra, rb, rs, $sformatf("rnd%0d", i));
            check_res($sformatf("rnd%0d", i), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
